screen_framebuffer: RTL and testbench

SCREEN_FRAMEBUFFER -- requirements
Module: screen_framebuffer

---
 rtl/screen_framebuffer.sv | 180 ++++++++++++++++++
 tb/tb_screen_framebuffer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/screen_framebuffer.sv
// Purpose : double-buffered 32x32x3 framebuffer; CPU draws into the back buffer, scan driver reads the front.
// Latency : bus read/write ack and scan pixel pair are registered, one cycle after the request.
// Backpres: no stall path; bus accesses arriving while a clear is running are dropped (no ack).
//
// Ports:
//   clk, reset                      clock, asynchronous active-low reset
//   bus_we, bus_re, bus_addr[9:0]   CPU pixel access, addr = {y[4:0], x[4:0]}
//   bus_wdata[2:0], bus_rdata[2:0]  pixel {R,G,B}
//   bus_ack                         one-cycle pulse, access accepted
//   swap_req, frame_end             front/back exchange request, applied at a frame boundary
//   clear_req, busy                 back-buffer clear request, high while any clear runs
//   swap_pending, front_sel         swap bookkeeping, index of the displayed buffer
//   scan_req, scan_row, scan_col    scan driver request for pixels (row,col) and (row+16,col)
//   scan_valid, R0..B1              one-cycle pulse, pixel pair from the front buffer
module screen_framebuffer (
   input  logic       clk,
   input  logic       reset,
   input  logic       bus_we,
   input  logic       bus_re,
   input  logic [9:0] bus_addr,
   input  logic [2:0] bus_wdata,
   output logic [2:0] bus_rdata,
   output logic       bus_ack,
   input  logic       swap_req,
   input  logic       clear_req,
   output logic       busy,
   output logic       swap_pending,
   output logic       front_sel,
   input  logic       frame_end,
   input  logic       scan_req,
   input  logic [3:0] scan_row,
   input  logic [4:0] scan_col,
   output logic       scan_valid,
   output logic       R0,
   output logic       G0,
   output logic       B0,
   output logic       R1,
   output logic       G1,
   output logic       B1
);

   typedef enum logic [1:0] {
      CLR_ALL  = 2'd0,
      IDLE     = 2'd1,
      CLR_BACK = 2'd2
   } state_t;

   state_t     state, state_nxt;
   logic [8:0] clear_addr, clear_addr_nxt;

   // Array index = {buffer, half}: 0/1 = buffer 0 top/bottom, 2/3 = buffer 1 top/bottom.
   // Splitting by half lets both scan pixels be read in the same cycle.
   logic [2:0] mem [0:3][0:511];
   logic [3:0] mem_we;
   logic [8:0] mem_waddr;
   logic [2:0] mem_wdata;

   logic       idle;
   logic [1:0] bus_idx;
   logic [1:0] scan_top_idx;
   logic [1:0] scan_bot_idx;
   logic [8:0] scan_addr;

   assign idle         = (state == IDLE);
   assign bus_idx      = {~front_sel, bus_addr[9]};
   assign scan_top_idx = {front_sel, 1'b0};
   assign scan_bot_idx = {front_sel, 1'b1};
   assign scan_addr    = {scan_row, scan_col};

   // ---------------- control FSM ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= CLR_ALL;
         clear_addr <= '0;
         busy       <= 1'b1;
      end else begin
         state      <= state_nxt;
         clear_addr <= clear_addr_nxt;
         busy       <= (state_nxt != IDLE);
      end
   end

   always_comb begin
      state_nxt      = state;
      clear_addr_nxt = clear_addr;
      case (state)
         CLR_ALL, CLR_BACK: begin
            // clear_addr wraps back to 0 on the final write
            clear_addr_nxt = clear_addr + 9'd1;
            if (clear_addr == 9'd511) state_nxt = IDLE;
         end
         IDLE: begin
            if (clear_req) begin
               state_nxt      = CLR_BACK;
               clear_addr_nxt = '0;
            end
         end
         default: begin
            state_nxt      = CLR_ALL;
            clear_addr_nxt = '0;
         end
      endcase
   end

   // ---------------- array write port ----------------
   // Clears and CPU writes never coincide: CPU writes are only taken in IDLE.
   always_comb begin
      mem_we    = '0;
      mem_waddr = clear_addr;
      mem_wdata = '0;
      case (state)
         CLR_ALL:  mem_we = 4'b1111;
         CLR_BACK: mem_we = front_sel ? 4'b0011 : 4'b1100;
         IDLE: begin
            if (bus_we) begin
               mem_we[bus_idx] = 1'b1;
               mem_waddr       = bus_addr[8:0];
               mem_wdata       = bus_wdata;
            end
         end
         default: mem_we = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (mem_we[i[1:0]]) mem[i[1:0]][mem_waddr] <= mem_wdata;
      end
   end

   // ---------------- CPU bus ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus_ack   <= 1'b0;
         bus_rdata <= '0;
      end else begin
         bus_ack <= 1'b0;
         if (idle) begin
            if (bus_we) begin
               bus_ack <= 1'b1;
            end else if (bus_re) begin
               bus_ack   <= 1'b1;
               bus_rdata <= mem[bus_idx][bus_addr[8:0]];
            end
         end
      end
   end

   // ---------------- front/back swap ----------------
   // A swap only lands on a frame boundary with no clear running, so the
   // buffer being cleared can never become the displayed one mid-clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         front_sel    <= 1'b0;
         swap_pending <= 1'b0;
      end else if (frame_end && swap_pending && !busy) begin
         front_sel    <= ~front_sel;
         swap_pending <= 1'b0;
      end else if (swap_req) begin
         swap_pending <= 1'b1;
      end
   end

   // ---------------- scan read port ----------------
   // Uses front_sel before any same-edge toggle; outputs hold between requests.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scan_valid   <= 1'b0;
         {R0, G0, B0} <= '0;
         {R1, G1, B1} <= '0;
      end else begin
         scan_valid <= scan_req;
         if (scan_req) begin
            {R0, G0, B0} <= mem[scan_top_idx][scan_addr];
            {R1, G1, B1} <= mem[scan_bot_idx][scan_addr];
         end
      end
   end

endmodule

// File: tb/tb_screen_framebuffer.sv
// Bench for screen_framebuffer: reference model on a [buffer][y][x] pixel array,
// table of hand-computed vectors, hand sequences for clear/swap/reset corners,
// then randomized traffic checked cycle by cycle against the model.
module tb_screen_framebuffer;

   logic       clk = 1'b0;
   logic       reset;
   logic       bus_we, bus_re, swap_req, clear_req, frame_end, scan_req;
   logic [9:0] bus_addr;
   logic [2:0] bus_wdata, bus_rdata;
   logic [3:0] scan_row;
   logic [4:0] scan_col;
   logic       bus_ack, busy, swap_pending, front_sel, scan_valid;
   logic       R0, G0, B0, R1, G1, B1;

   always #5 clk = ~clk;

   screen_framebuffer dut (
      .clk(clk), .reset(reset),
      .bus_we(bus_we), .bus_re(bus_re), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
      .swap_req(swap_req), .clear_req(clear_req), .busy(busy),
      .swap_pending(swap_pending), .front_sel(front_sel), .frame_end(frame_end),
      .scan_req(scan_req), .scan_row(scan_row), .scan_col(scan_col),
      .scan_valid(scan_valid),
      .R0(R0), .G0(G0), .B0(B0), .R1(R1), .G1(G1), .B1(B1)
   );

   int n_chk  = 0;
   int n_fail = 0;

   // ---------------- reference model ----------------
   logic [2:0] fb [2][32][32];   // [buffer][y][x]
   int         clr_left;         // pixels-pairs still to clear, 0 = not clearing
   bit         clr_all;
   bit         m_front, m_pend;
   bit         e_ack, e_valid;
   logic [2:0] e_rdata, e_rgb0, e_rgb1;

   task automatic model_reset();
      clr_left = 512;
      clr_all  = 1'b1;
      m_front  = 1'b0;
      m_pend   = 1'b0;
      e_ack    = 1'b0;
      e_valid  = 1'b0;
      e_rdata  = '0;
      e_rgb0   = '0;
      e_rgb1   = '0;
   endtask

   task automatic model_step(input bit we, input bit re, input logic [9:0] a,
                             input logic [2:0] wd, input bit sw, input bit fe,
                             input bit cr, input bit sr, input logic [3:0] row,
                             input logic [4:0] col);
      bit busy_now;
      int idx;
      busy_now = (clr_left > 0);
      e_valid  = sr;
      if (sr) begin
         e_rgb0 = fb[m_front][int'(row)][col];
         e_rgb1 = fb[m_front][int'(row) + 16][col];
      end
      e_ack = 1'b0;
      if (!busy_now) begin
         if (we) begin
            fb[!m_front][a[9:5]][a[4:0]] = wd;
            e_ack = 1'b1;
         end else if (re) begin
            e_rdata = fb[!m_front][a[9:5]][a[4:0]];
            e_ack   = 1'b1;
         end
      end
      if (busy_now) begin
         idx = 512 - clr_left;
         for (int b = 0; b < 2; b++) begin
            if (clr_all || b != int'(m_front)) begin
               fb[b][idx / 32][idx % 32]      = 3'd0;
               fb[b][idx / 32 + 16][idx % 32] = 3'd0;
            end
         end
         clr_left--;
         if (clr_left == 0) clr_all = 1'b0;
      end else if (cr) begin
         clr_left = 512;
         clr_all  = 1'b0;
      end
      if (fe && m_pend && !busy_now) begin
         m_front = !m_front;
         m_pend  = 1'b0;
      end else if (sw) begin
         m_pend = 1'b1;
      end
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("ack",   int'(bus_ack),      int'(e_ack));
      chk("rdata", int'(bus_rdata),    int'(e_rdata));
      chk("busy",  int'(busy),         (clr_left > 0) ? 1 : 0);
      chk("pend",  int'(swap_pending), int'(m_pend));
      chk("front", int'(front_sel),    int'(m_front));
      chk("valid", int'(scan_valid),   int'(e_valid));
      chk("rgb0",  int'({R0, G0, B0}), int'(e_rgb0));
      chk("rgb1",  int'({R1, G1, B1}), int'(e_rgb1));
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic step(input bit we, input bit re, input logic [9:0] a,
                       input logic [2:0] wd, input bit sw, input bit fe,
                       input bit cr, input bit sr, input logic [3:0] row,
                       input logic [4:0] col);
      bus_we = we; bus_re = re; bus_addr = a; bus_wdata = wd;
      swap_req = sw; frame_end = fe; clear_req = cr;
      scan_req = sr; scan_row = row; scan_col = col;
      @(posedge clk);
      model_step(we, re, a, wd, sw, fe, cr, sr, row, col);
      #1;
      check_all();
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 10'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 5'd0);
   endtask
   task automatic bwr(input logic [9:0] a, input logic [2:0] wd);
      step(1'b1, 1'b0, a, wd, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 5'd0);
   endtask
   task automatic brd(input logic [9:0] a);
      step(1'b0, 1'b1, a, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 5'd0);
   endtask
   task automatic scan(input logic [3:0] row, input logic [4:0] col);
      step(1'b0, 1'b0, 10'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, row, col);
   endtask
   task automatic ctl(input bit sw, input bit fe, input bit cr);
      step(1'b0, 1'b0, 10'd0, 3'd0, sw, fe, cr, 1'b0, 4'd0, 5'd0);
   endtask
   task automatic rnd_step(input bit no_ctl);
      step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 30,
           10'($urandom), 3'($urandom),
           !no_ctl && ($urandom_range(0, 99) < 5), !no_ctl && ($urandom_range(0, 99) < 6),
           !no_ctl && ($urandom_range(0, 199) < 1), $urandom_range(0, 99) < 40,
           4'($urandom), 5'($urandom));
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit         we, re;
      logic [9:0] a;
      logic [2:0] wd;
      bit         sw, fe, cr, sr;
      logic [3:0] row;
      logic [4:0] col;
      bit         x_ack;
      logic [2:0] x_rdata;
      bit         x_pend, x_front, x_valid;
      logic [2:0] x_rgb0, x_rgb1;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(bit we, bit re, logic [9:0] a, logic [2:0] wd,
                               bit sw, bit fe, bit sr, logic [3:0] row, logic [4:0] col,
                               bit xa, logic [2:0] xr, bit xp, bit xf, bit xv,
                               logic [2:0] x0, logic [2:0] x1);
      vec_t v;
      v.we = we; v.re = re; v.a = a; v.wd = wd; v.sw = sw; v.fe = fe; v.cr = 1'b0;
      v.sr = sr; v.row = row; v.col = col;
      v.x_ack = xa; v.x_rdata = xr; v.x_pend = xp; v.x_front = xf; v.x_valid = xv;
      v.x_rgb0 = x0; v.x_rgb1 = x1;
      return v;
   endfunction

   int n;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int b = 0; b < 2; b++)
         for (int y = 0; y < 32; y++)
            for (int x = 0; x < 32; x++) fb[b][y][x] = 3'd7;
      bus_we = 0; bus_re = 0; bus_addr = '0; bus_wdata = '0;
      swap_req = 0; frame_end = 0; clear_req = 0;
      scan_req = 0; scan_row = '0; scan_col = '0;

      // ---- power-on reset: values forced while reset is low ----
      reset = 1'b1;
      #2 reset = 1'b0;
      model_reset();
      #1 check_all();
      repeat (3) @(negedge clk);
      reset = 1'b1;

      // ---- CLR_ALL lasts exactly 512 cycles ----
      n = 0;
      while (busy && n < 600) begin
         idle();
         n++;
      end
      chk("clr_all_cycles", n, 512);

      // ---- every scan position reads zero after the initial clear ----
      for (int r = 0; r < 16; r++)
         for (int c = 0; c < 32; c++) scan(4'(r), 5'(c));

      // ---- table-driven vectors ----
      tbl.push_back(mk(1, 0, 10'h3FF, 3'd5, 0, 0, 0, 4'd0,  5'd0,  1, 3'd0, 0, 0, 0, 3'd0, 3'd0));
      tbl.push_back(mk(0, 1, 10'h3FF, 3'd0, 0, 0, 0, 4'd0,  5'd0,  1, 3'd5, 0, 0, 0, 3'd0, 3'd0));
      tbl.push_back(mk(0, 0, 10'h000, 3'd0, 0, 0, 1, 4'd15, 5'd31, 0, 3'd5, 0, 0, 1, 3'd0, 3'd0));
      tbl.push_back(mk(0, 0, 10'h000, 3'd0, 1, 0, 0, 4'd0,  5'd0,  0, 3'd5, 1, 0, 0, 3'd0, 3'd0));
      for (int i = 0; i < 9; i++)
         tbl.push_back(mk(0, 0, 10'h000, 3'd0, 0, 0, 0, 4'd0, 5'd0, 0, 3'd5, 1, 0, 0, 3'd0, 3'd0));
      tbl.push_back(mk(0, 0, 10'h000, 3'd0, 0, 1, 0, 4'd0,  5'd0,  0, 3'd5, 0, 1, 0, 3'd0, 3'd0));
      tbl.push_back(mk(0, 0, 10'h000, 3'd0, 0, 0, 1, 4'd15, 5'd31, 0, 3'd5, 0, 1, 1, 3'd0, 3'd5));
      tbl.push_back(mk(0, 0, 10'h000, 3'd0, 1, 1, 0, 4'd0,  5'd0,  0, 3'd5, 1, 1, 0, 3'd0, 3'd5));
      tbl.push_back(mk(0, 1, 10'h3FF, 3'd0, 0, 0, 0, 4'd0,  5'd0,  1, 3'd0, 1, 1, 0, 3'd0, 3'd5));
      tbl.push_back(mk(1, 1, 10'h000, 3'd3, 0, 0, 0, 4'd0,  5'd0,  1, 3'd0, 1, 1, 0, 3'd0, 3'd5));
      tbl.push_back(mk(0, 0, 10'h000, 3'd0, 0, 1, 1, 4'd0,  5'd0,  0, 3'd0, 0, 0, 1, 3'd0, 3'd0));
      tbl.push_back(mk(0, 0, 10'h000, 3'd0, 0, 0, 1, 4'd0,  5'd0,  0, 3'd0, 0, 0, 1, 3'd3, 3'd0));
      tbl.push_back(mk(0, 0, 10'h000, 3'd0, 0, 0, 0, 4'd0,  5'd0,  0, 3'd0, 0, 0, 0, 3'd3, 3'd0));
      foreach (tbl[i]) begin
         step(tbl[i].we, tbl[i].re, tbl[i].a, tbl[i].wd, tbl[i].sw, tbl[i].fe,
              tbl[i].cr, tbl[i].sr, tbl[i].row, tbl[i].col);
         chk($sformatf("v%0d_ack", i),   int'(bus_ack),      int'(tbl[i].x_ack));
         chk($sformatf("v%0d_rdata", i), int'(bus_rdata),    int'(tbl[i].x_rdata));
         chk($sformatf("v%0d_pend", i),  int'(swap_pending), int'(tbl[i].x_pend));
         chk($sformatf("v%0d_front", i), int'(front_sel),    int'(tbl[i].x_front));
         chk($sformatf("v%0d_valid", i), int'(scan_valid),   int'(tbl[i].x_valid));
         chk($sformatf("v%0d_rgb0", i),  int'({R0, G0, B0}), int'(tbl[i].x_rgb0));
         chk($sformatf("v%0d_rgb1", i),  int'({R1, G1, B1}), int'(tbl[i].x_rgb1));
      end

      // ---- clear of back buffer: dropped write, deferred swap ----
      bwr(10'h021, 3'd3);
      chk("cb_pre_ack", int'(bus_ack), 1);
      ctl(1'b0, 1'b0, 1'b1);
      chk("cb_busy", int'(busy), 1);
      bwr(10'h021, 3'd7);
      chk("cb_drop_ack", int'(bus_ack), 0);
      ctl(1'b1, 1'b0, 1'b0);
      chk("cb_pend", int'(swap_pending), 1);
      ctl(1'b0, 1'b1, 1'b0);
      chk("cb_no_toggle", int'(front_sel), 0);
      chk("cb_still_pend", int'(swap_pending), 1);
      n = 0;
      while (busy && n < 600) begin
         idle();
         n++;
      end
      chk("cb_remaining_cycles", n, 509);
      ctl(1'b0, 1'b1, 1'b0);
      chk("cb_toggle", int'(front_sel), 1);
      chk("cb_pend_clr", int'(swap_pending), 0);
      scan(4'd1, 5'd1);
      chk("cb_cleared_pix", int'({R0, G0, B0}), 0);
      scan(4'd15, 5'd31);
      chk("cb_cleared_3ff", int'({R1, G1, B1}), 0);
      brd(10'h000);
      chk("cb_other_buf_kept", int'(bus_rdata), 3);

      // ---- reset in the middle of CLR_BACK ----
      bwr(10'h055, 3'd6);
      brd(10'h055);
      chk("mr_rdata", int'(bus_rdata), 6);
      ctl(1'b1, 1'b0, 1'b0);
      ctl(1'b0, 1'b1, 1'b0);
      scan(4'd2, 5'd21);
      chk("mr_scan", int'({R0, G0, B0}), 6);
      ctl(1'b1, 1'b0, 1'b0);
      ctl(1'b0, 1'b1, 1'b0);
      ctl(1'b1, 1'b0, 1'b0);
      ctl(1'b0, 1'b0, 1'b1);
      repeat (200) idle();
      chk("mr_pre_front", int'(front_sel), 1);
      chk("mr_pre_pend", int'(swap_pending), 1);
      reset = 1'b0;
      model_reset();
      #1;
      check_all();
      chk("mr_front", int'(front_sel), 0);
      chk("mr_pend", int'(swap_pending), 0);
      chk("mr_busy", int'(busy), 1);
      chk("mr_rdata0", int'(bus_rdata), 0);
      chk("mr_rgb0", int'({R0, G0, B0}), 0);
      #1 reset = 1'b1;
      n = 0;
      while (busy && n < 600) begin
         rnd_step(1'b1);
         n++;
      end
      chk("mr_clr_all_cycles", n, 512);
      chk("mr_front_after", int'(front_sel), 0);

      // ---- randomized traffic against the model ----
      for (int i = 0; i < 3000; i++) rnd_step(1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
